// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiply writeback stage
package mul_pkg;

  localparam int MUL_XLEN      = 32;
  localparam int MUL_ROB_IDX_W = 4;
  localparam int EXC_W         = 3;

  localparam logic [2:0] INSTR_NOT_MUL = 3'd0;
  localparam logic [2:0] INSTR_MUL     = 3'd1;
  localparam logic [2:0] INSTR_MULH    = 3'd2;
  localparam logic [2:0] INSTR_MULHSU  = 3'd3;
  localparam logic [2:0] INSTR_MULHU   = 3'd4;

  localparam logic [EXC_W-1:0] EXC_NONE     = 3'b000;
  localparam logic [EXC_W-1:0] EXC_OVERFLOW = 3'b001;
  localparam logic [EXC_W-1:0] EXC_ILLEGAL  = 3'b010;
  localparam logic [EXC_W-1:0] EXC_MISC     = 3'b100;

  typedef struct packed {
    logic [MUL_XLEN-1:0]      value;
    logic [MUL_ROB_IDX_W-1:0] rob_idx;
    logic [EXC_W-1:0]         exc;
  } wb_entry_t;

  function automatic logic is_mul(input logic [2:0] instr_type);
    return instr_type != INSTR_NOT_MUL;
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// rtl/mul_wb_fifo.sv - in-order holding FIFO for multiply results that lost arbitration
module mul_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 39,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// rtl/mul_wb_arbiter.sv - M5 ROB writeback arbiter (ALU priority, buffered mul); MUL_WB_PERF_EN adds conflict counter
module mul_wb_arbiter
  import mul_pkg::*;
#(
  parameter int XLEN      = MUL_XLEN,
  parameter int ROB_IDX_W = MUL_ROB_IDX_W,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      in_mul_out,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [2:0]           in_exception_vector,
  input  logic [2:0]           in_instr_type,
  input  logic                 in_alu_valid,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [ROB_IDX_W-1:0] in_alu_rob_idx,
  input  logic [2:0]           in_alu_exception_vector,
  output logic                 out_rob_we,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [XLEN-1:0]      out_rob_value,
  output logic [2:0]           out_rob_exception_vector,
  output logic                 out_mul_stall,
`ifdef MUL_WB_PERF_EN
  output logic [15:0]          out_conflict_cnt,
`endif
  output logic                 out_overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + ROB_IDX_W + EXC_W;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH-1);

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [EXC_W-1:0]     exc;
  } entry_t;

  entry_t        mul_entry, alu_entry, fifo_head, win_entry;
  logic [EW-1:0] fifo_head_raw;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic          mul_valid, sel_fifo, sel_mul, fifo_push, drop;

  logic                 rob_we_q, rob_we_d;
  logic [ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;
  logic [XLEN-1:0]      rob_value_q, rob_value_d;
  logic [2:0]           rob_exc_q, rob_exc_d;
  logic                 overflow_q, overflow_d;

  assign mul_valid = is_mul(in_instr_type);
  assign mul_entry = '{value: in_mul_out, rob_idx: in_rob_idx, exc: in_exception_vector};
  assign alu_entry = '{value: in_alu_result, rob_idx: in_alu_rob_idx, exc: in_alu_exception_vector};
  assign fifo_head = entry_t'(fifo_head_raw);

  // Bypass only when nothing older is waiting, which keeps mul results in arrival order.
  assign sel_fifo  = !in_alu_valid && !fifo_empty;
  assign sel_mul   = !in_alu_valid && fifo_empty && mul_valid;
  assign fifo_push = mul_valid && !sel_mul;
  assign drop      = fifo_push && fifo_full && !sel_fifo;

  mul_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (EW'(mul_entry)),
    .pop       (sel_fifo),
    .head      (fifo_head_raw),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    win_entry   = alu_entry;
    rob_we_d    = 1'b0;
    rob_idx_d   = rob_idx_q;
    rob_value_d = rob_value_q;
    rob_exc_d   = rob_exc_q;
    overflow_d  = overflow_q | drop;
    if (sel_fifo)     win_entry = fifo_head;
    else if (sel_mul) win_entry = mul_entry;
    if (in_alu_valid || sel_fifo || sel_mul) begin
      rob_we_d    = 1'b1;
      rob_idx_d   = win_entry.rob_idx;
      rob_value_d = win_entry.value;
      rob_exc_d   = win_entry.exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rob_we_q    <= 1'b0;
      rob_idx_q   <= '0;
      rob_value_q <= '0;
      rob_exc_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rob_we_q    <= rob_we_d;
      rob_idx_q   <= rob_idx_d;
      rob_value_q <= rob_value_d;
      rob_exc_q   <= rob_exc_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_rob_we               = rob_we_q;
  assign out_rob_idx              = rob_idx_q;
  assign out_rob_value            = rob_value_q;
  assign out_rob_exception_vector = rob_exc_q;
  assign out_overflow             = overflow_q;
  // Raised one entry early so the in-flight M4/M5 result still has a slot.
  assign out_mul_stall            = (fifo_count >= STALL_LVL);

`ifdef MUL_WB_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (in_alu_valid && (mul_valid || !fifo_empty) && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign out_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// tb/tb_mul_wb_arbiter.sv - directed self-checking bench for mul_wb_arbiter
module tb_mul_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_mul_out = '0;
  logic [3:0]  in_rob_idx = '0;
  logic [2:0]  in_exception_vector = '0;
  logic [2:0]  in_instr_type = '0;
  logic        in_alu_valid = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [3:0]  in_alu_rob_idx = '0;
  logic [2:0]  in_alu_exception_vector = '0;
  logic        out_rob_we;
  logic [3:0]  out_rob_idx;
  logic [31:0] out_rob_value;
  logic [2:0]  out_rob_exception_vector;
  logic        out_mul_stall;
  logic        out_overflow;
`ifdef MUL_WB_PERF_EN
  logic [15:0] out_conflict_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mul_wb_arbiter dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_mul_out               (in_mul_out),
    .in_rob_idx               (in_rob_idx),
    .in_exception_vector      (in_exception_vector),
    .in_instr_type            (in_instr_type),
    .in_alu_valid             (in_alu_valid),
    .in_alu_result            (in_alu_result),
    .in_alu_rob_idx           (in_alu_rob_idx),
    .in_alu_exception_vector  (in_alu_exception_vector),
    .out_rob_we               (out_rob_we),
    .out_rob_idx              (out_rob_idx),
    .out_rob_value            (out_rob_value),
    .out_rob_exception_vector (out_rob_exception_vector),
    .out_mul_stall            (out_mul_stall),
`ifdef MUL_WB_PERF_EN
    .out_conflict_cnt         (out_conflict_cnt),
`endif
    .out_overflow             (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic alu_v, input logic [3:0] alu_idx, input logic [31:0] alu_val,
                       input logic [2:0] mtype, input logic [3:0] midx, input logic [31:0] mval,
                       input logic [2:0] mexc);
    in_alu_valid            = alu_v;
    in_alu_rob_idx          = alu_idx;
    in_alu_result           = alu_val;
    in_alu_exception_vector = 3'b000;
    in_instr_type           = mtype;
    in_rob_idx              = midx;
    in_mul_out              = mval;
    in_exception_vector     = mexc;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 3'd0, 4'd0, 32'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [3:0] idx, input logic [31:0] val);
    check({tag, "_we"}, 64'(out_rob_we), 64'd1);
    check({tag, "_idx"}, 64'(out_rob_idx), 64'(idx));
    check({tag, "_val"}, 64'(out_rob_value), 64'(val));
  endtask

  initial begin
    idle();
    repeat (2) tick();
    check("rst_we", 64'(out_rob_we), 64'd0);
    check("rst_idx", 64'(out_rob_idx), 64'd0);
    check("rst_val", 64'(out_rob_value), 64'd0);
    check("rst_exc", 64'(out_rob_exception_vector), 64'd0);
    check("rst_stall", 64'(out_mul_stall), 64'd0);
    check("rst_ovf", 64'(out_overflow), 64'd0);
    reset = 1'b1;

    // Bypass
    drive(1'b0, 4'd0, 32'd0, 3'd1, 4'd3, 32'h10, 3'b000);
    check("byp_stall_c0", 64'(out_mul_stall), 64'd0);
    tick();
    expect_wr("byp", 4'd3, 32'h10);
    check("byp_stall_c1", 64'(out_mul_stall), 64'd0);
    idle();
    tick();
    check("byp_idle_we", 64'(out_rob_we), 64'd0);
    check("byp_hold_idx", 64'(out_rob_idx), 64'd3);
    check("byp_hold_val", 64'(out_rob_value), 64'h10);

    // Conflict buffering
    drive(1'b1, 4'd5, 32'h55, 3'd1, 4'd7, 32'hA, 3'b000);
    tick();
    expect_wr("cf_c1", 4'd5, 32'h55);
    check("cf_stall_c1", 64'(out_mul_stall), 64'd1);
    drive(1'b1, 4'd6, 32'h66, 3'd1, 4'd8, 32'hB, 3'b000);
    tick();
    expect_wr("cf_c2", 4'd6, 32'h66);
    check("cf_stall_c2", 64'(out_mul_stall), 64'd1);
    idle();
    tick();
    expect_wr("cf_c3", 4'd7, 32'hA);
    tick();
    expect_wr("cf_c4", 4'd8, 32'hB);
    check("cf_stall_c4", 64'(out_mul_stall), 64'd0);
    tick();
    check("cf_c5_we", 64'(out_rob_we), 64'd0);

    // Exception passthrough
    drive(1'b0, 4'd0, 32'd0, 3'd2, 4'd9, 32'h99, 3'b010);
    tick();
    expect_wr("exc", 4'd9, 32'h99);
    check("exc_vec", 64'(out_rob_exception_vector), 64'b010);
    idle();
    tick();

    // Simultaneous push/pop
    drive(1'b1, 4'd4, 32'h44, 3'd1, 4'd1, 32'h11, 3'b000);
    tick();
    expect_wr("pp_alu", 4'd4, 32'h44);
    check("pp_stall_a", 64'(out_mul_stall), 64'd1);
    drive(1'b0, 4'd0, 32'd0, 3'd3, 4'd2, 32'h22, 3'b000);
    tick();
    expect_wr("pp_head", 4'd1, 32'h11);
    check("pp_count_kept", 64'(out_mul_stall), 64'd1);
    idle();
    tick();
    expect_wr("pp_new", 4'd2, 32'h22);
    check("pp_stall_c", 64'(out_mul_stall), 64'd0);
    tick();

    // Overflow
    drive(1'b1, 4'd10, 32'hA0, 3'd1, 4'd13, 32'hD0, 3'b000);
    tick();
    expect_wr("ov_a0", 4'd10, 32'hA0);
    drive(1'b1, 4'd11, 32'hA1, 3'd1, 4'd14, 32'hE0, 3'b000);
    tick();
    expect_wr("ov_a1", 4'd11, 32'hA1);
    check("ov_pre", 64'(out_overflow), 64'd0);
    drive(1'b1, 4'd12, 32'hA2, 3'd1, 4'd15, 32'hF0, 3'b000);
    tick();
    expect_wr("ov_a2", 4'd12, 32'hA2);
    check("ov_set", 64'(out_overflow), 64'd1);
    idle();
    tick();
    expect_wr("ov_d0", 4'd13, 32'hD0);
    tick();
    expect_wr("ov_d1", 4'd14, 32'hE0);
    tick();
    check("ov_no_third", 64'(out_rob_we), 64'd0);
    check("ov_sticky", 64'(out_overflow), 64'd1);

    // Reset mid-stream with two entries buffered
    drive(1'b1, 4'd1, 32'h1, 3'd1, 4'd2, 32'h2, 3'b000);
    tick();
    drive(1'b1, 4'd3, 32'h3, 3'd1, 4'd4, 32'h4, 3'b000);
    tick();
    idle();
    #2 reset = 1'b0;
    #1;
    check("mr_we", 64'(out_rob_we), 64'd0);
    check("mr_stall", 64'(out_mul_stall), 64'd0);
    check("mr_ovf", 64'(out_overflow), 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mr_stale_%0d", i), 64'(out_rob_we), 64'd0);
    end
    drive(1'b0, 4'd0, 32'd0, 3'd1, 4'd6, 32'h60, 3'b000);
    tick();
    expect_wr("mr_after", 4'd6, 32'h60);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
